// File: rtl/ysyx_22040000_mp_regfile_pkg.sv
// Shared types and default geometry for the NPC multi-ported integer register file.
package ysyx_22040000_mp_regfile_pkg;

    localparam int RF_AWIDTH = 5;
    localparam int RF_DWIDTH = 32;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/ysyx_22040000_rf_wsel.sv
// Priority selector over the write ports for one address: the highest-index
// enabled port whose address matches wins.
module ysyx_22040000_rf_wsel
    import ysyx_22040000_mp_regfile_pkg::*;
#(
    parameter int AWIDTH = RF_AWIDTH,
    parameter int DWIDTH = RF_DWIDTH,
    parameter int NWRITE = 1
) (
    input  logic [AWIDTH-1:0]        addr,
    input  logic [NWRITE-1:0]        wen_eff,
    input  logic [NWRITE*AWIDTH-1:0] waddr,
    input  logic [NWRITE*DWIDTH-1:0] wdata,
    output logic                     hit,
    output logic [DWIDTH-1:0]        data
);

    logic match_s;

    // Ascending scan so later (higher-index) matches overwrite earlier ones.
    always_comb begin
        hit     = 1'b0;
        data    = {DWIDTH{1'b0}};
        match_s = 1'b0;
        for (int i = 0; i < NWRITE; i++) begin
            match_s = wen_eff[i] && (waddr[i*AWIDTH +: AWIDTH] == addr);
            hit     = hit | match_s;
            data    = match_s ? wdata[i*DWIDTH +: DWIDTH] : data;
        end
    end

endmodule

// File: rtl/ysyx_22040000_mp_regfile.sv
// Multi-ported integer register file with optional bypass, hard-wired zero
// register and a sequential clear engine run after reset or on clr_req.
module ysyx_22040000_mp_regfile
    import ysyx_22040000_mp_regfile_pkg::*;
#(
    parameter int AWIDTH   = RF_AWIDTH,
    parameter int DWIDTH   = RF_DWIDTH,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*AWIDTH-1:0] waddr,
    input  logic [NWRITE*DWIDTH-1:0] wdata,
    input  logic [NREAD*AWIDTH-1:0]  raddr,
    output logic [NREAD*DWIDTH-1:0]  rdata,
    output logic                     busy,
    output logic                     wr_conflict,
    input  logic [AWIDTH-1:0]        dbg_addr,
    output logic [DWIDTH-1:0]        dbg_data
);

    localparam int DEPTH = 2 ** AWIDTH;

    rf_state_e         state_r;
    rf_state_e         state_nxt_s;
    logic [AWIDTH-1:0] cnt_r;
    logic [AWIDTH-1:0] cnt_nxt_s;
    logic              ready_s;
    logic [NWRITE-1:0] wen_eff_s;
    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  ent_hit_s;
    logic [DWIDTH-1:0] ent_data_s [DEPTH];

    assign ready_s = (state_r == ST_READY);
    assign busy    = ~ready_s;

    // Clear sequencer state and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {AWIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state: the clear runs to the all-ones entry and cannot be restarted by clr_req.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                cnt_nxt_s = cnt_r + AWIDTH'(1);
                if (cnt_r == {AWIDTH{1'b1}}) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = {AWIDTH{1'b0}};
                end else begin
                    state_nxt_s = ST_READY;
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = {AWIDTH{1'b0}};
            end
        endcase
    end

    for (genvar i = 0; i < NWRITE; i++) begin : g_weff
        assign wen_eff_s[i] = wen[i] && ready_s &&
            !((ZERO_REG != 0) && (waddr[i*AWIDTH +: AWIDTH] == {AWIDTH{1'b0}}));
    end

    // Pairwise compare of effective write addresses.
    always_comb begin
        wr_conflict = 1'b0;
        for (int i = 0; i < NWRITE; i++) begin
            for (int j = i + 1; j < NWRITE; j++) begin
                wr_conflict = wr_conflict | (wen_eff_s[i] & wen_eff_s[j] &
                    (waddr[i*AWIDTH +: AWIDTH] == waddr[j*AWIDTH +: AWIDTH]));
            end
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        ysyx_22040000_rf_wsel #(
            .AWIDTH (AWIDTH),
            .DWIDTH (DWIDTH),
            .NWRITE (NWRITE)
        ) u_wsel (
            .addr    (AWIDTH'(e)),
            .wen_eff (wen_eff_s),
            .waddr   (waddr),
            .wdata   (wdata),
            .hit     (ent_hit_s[e]),
            .data    (ent_data_s[e])
        );
    end

    // Array update: clear engine has the port while busy, otherwise winning writes commit.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (!ready_s && (cnt_r == AWIDTH'(e))) begin
                mem_r[e] <= {DWIDTH{1'b0}};
            end else if (ent_hit_s[e]) begin
                mem_r[e] <= ent_data_s[e];
            end else begin
                mem_r[e] <= mem_r[e];
            end
        end
    end

    for (genvar j = 0; j < NREAD; j++) begin : g_rd
        logic [AWIDTH-1:0] ra_s;
        logic              byp_hit_s;
        logic [DWIDTH-1:0] byp_data_s;
        logic [DWIDTH-1:0] rd_s;

        assign ra_s = raddr[j*AWIDTH +: AWIDTH];

        ysyx_22040000_rf_wsel #(
            .AWIDTH (AWIDTH),
            .DWIDTH (DWIDTH),
            .NWRITE (NWRITE)
        ) u_byp (
            .addr    (ra_s),
            .wen_eff (wen_eff_s),
            .waddr   (waddr),
            .wdata   (wdata),
            .hit     (byp_hit_s),
            .data    (byp_data_s)
        );

        // Read mux: contents are not trusted until the clear finishes.
        always_comb begin
            rd_s = {DWIDTH{1'b0}};
            if (!ready_s) begin
                rd_s = {DWIDTH{1'b0}};
            end else if ((ZERO_REG != 0) && (ra_s == {AWIDTH{1'b0}})) begin
                rd_s = {DWIDTH{1'b0}};
            end else if ((BYPASS != 0) && byp_hit_s) begin
                rd_s = byp_data_s;
            end else begin
                rd_s = mem_r[ra_s];
            end
        end

        assign rdata[j*DWIDTH +: DWIDTH] = rd_s;
    end

    // Debug port sees the array only, never in-flight write data.
    always_comb begin
        dbg_data = {DWIDTH{1'b0}};
        if (!ready_s) begin
            dbg_data = {DWIDTH{1'b0}};
        end else if ((ZERO_REG != 0) && (dbg_addr == {AWIDTH{1'b0}})) begin
            dbg_data = {DWIDTH{1'b0}};
        end else begin
            dbg_data = mem_r[dbg_addr];
        end
    end

endmodule

// File: tb/tb_ysyx_22040000_mp_regfile.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor
// pops and compares. A second instance with BYPASS=0 shares all inputs.
module tb_ysyx_22040000_mp_regfile;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        busy;
    logic        wr_conflict;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [63:0] nb_rdata;
    logic        nb_busy;
    logic        nb_conflict;
    logic [31:0] nb_dbg_data;

    ysyx_22040000_mp_regfile #(
        .AWIDTH(5), .DWIDTH(32), .NREAD(2), .NWRITE(2), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .wen(wen), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rdata), .busy(busy),
        .wr_conflict(wr_conflict), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    ysyx_22040000_mp_regfile #(
        .AWIDTH(5), .DWIDTH(32), .NREAD(2), .NWRITE(2), .BYPASS(0), .ZERO_REG(1)
    ) dut_nb (
        .clk(clk), .rst(rst), .clr_req(clr_req), .wen(wen), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(nb_rdata), .busy(nb_busy),
        .wr_conflict(nb_conflict), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [5:0]  m;
        logic        busy;
        logic        conf;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] dbg;
        logic [31:0] nb1;
    } exp_t;

    localparam logic [5:0] M_B  = 6'b000001;
    localparam logic [5:0] M_C  = 6'b000010;
    localparam logic [5:0] M_R0 = 6'b000100;
    localparam logic [5:0] M_R1 = 6'b001000;
    localparam logic [5:0] M_D  = 6'b010000;
    localparam logic [5:0] M_N  = 6'b100000;
    localparam logic [5:0] M_ALL = 6'b111111;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic void push(input string tag, input logic [5:0] m, input logic b,
                                 input logic c, input logic [31:0] r0, input logic [31:0] r1,
                                 input logic [31:0] d, input logic [31:0] n);
        exp_t e;
        e.tag = tag; e.m = m; e.busy = b; e.conf = c;
        e.rd0 = r0; e.rd1 = r1; e.dbg = d; e.nb1 = n;
        sb_q.push_back(e);
    endfunction

    task automatic chk(input string tag, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, exp);
        end
    endtask

    // Monitor: outputs are combinational on the inputs driven after the previous posedge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.m[0]) chk(mon_e.tag, "busy", {31'd0, busy}, {31'd0, mon_e.busy});
            if (mon_e.m[1]) chk(mon_e.tag, "conf", {31'd0, wr_conflict}, {31'd0, mon_e.conf});
            if (mon_e.m[2]) chk(mon_e.tag, "rd0", rdata[31:0], mon_e.rd0);
            if (mon_e.m[3]) chk(mon_e.tag, "rd1", rdata[63:32], mon_e.rd1);
            if (mon_e.m[4]) chk(mon_e.tag, "dbg", dbg_data, mon_e.dbg);
            if (mon_e.m[5]) chk(mon_e.tag, "nb_rd1", nb_rdata[63:32], mon_e.nb1);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; wen = 2'b00; waddr = 10'd0; wdata = 64'd0;
        raddr = 10'd0; dbg_addr = 5'd0;

        // Reset state, with a write attempted that must not count
        sync();
        wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h0000_000B, 32'h0000_000A};
        raddr = {5'd9, 5'd5}; dbg_addr = 5'd7;
        push("reset", M_ALL, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Release reset; writes to x5 during the clear are dropped
        sync();
        rst = 1'b0; wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'h0000_0055};
        dbg_addr = 5'd5;
        push("clr0", M_B | M_C | M_R0 | M_R1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            sync();
            if (k == 32) wen = 2'b00;
            push($sformatf("clr%0d", k), M_B | M_C | M_R0 | M_D, (k < 32), 1'b0,
                 32'd0, 32'd0, 32'd0, 32'd0);
        end

        // Basic write with bypass, then registered read
        sync();
        wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEAD_BEEF};
        raddr = {5'd5, 5'd5}; dbg_addr = 5'd5;
        push("wr_x5", M_ALL, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 32'd0);
        sync();
        wen = 2'b00;
        push("rd_x5", M_ALL, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
             32'hDEAD_BEEF);

        // Both ports write x0: dropped, no conflict
        sync();
        wen = 2'b11; waddr = {5'd0, 5'd0}; wdata = {32'hFFFF_FFFF, 32'h1111_1111};
        raddr = {5'd5, 5'd0}; dbg_addr = 5'd0;
        push("wr_x0", M_ALL, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        sync();
        wen = 2'b00;
        push("rd_x0", M_R0 | M_D, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Bypass on read port 1; debug port and BYPASS=0 instance see the old value
        sync();
        wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h0000_1234};
        raddr = {5'd7, 5'd5}; dbg_addr = 5'd7;
        push("byp_x7", M_ALL, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 32'd0, 32'd0);
        sync();
        wen = 2'b00;
        push("rd_x7", M_R1 | M_D | M_N, 1'b0, 1'b0, 32'd0, 32'h0000_1234, 32'h0000_1234,
             32'h0000_1234);

        // Bypass from write port 1 alone
        sync();
        wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h0000_0099, 32'd0};
        raddr = {5'd9, 5'd7};
        push("byp_p1", M_C | M_R0 | M_R1 | M_N, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0099,
             32'd0, 32'd0);

        // Same-address conflict: port 1 wins
        sync();
        wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h0000_000B, 32'h0000_000A};
        raddr = {5'd7, 5'd3}; dbg_addr = 5'd3;
        push("conf_x3", M_ALL, 1'b0, 1'b1, 32'h0000_000B, 32'h0000_1234, 32'd0,
             32'h0000_1234);
        sync();
        wen = 2'b00;
        push("rd_x3", M_C | M_R0 | M_D, 1'b0, 1'b0, 32'h0000_000B, 32'd0, 32'h0000_000B,
             32'd0);

        // Two ports, distinct addresses
        sync();
        wen = 2'b11; waddr = {5'd11, 5'd10}; wdata = {32'h0000_0011, 32'h0000_0010};
        raddr = {5'd11, 5'd10};
        push("dual_wr", M_C | M_R0 | M_R1 | M_N, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0011,
             32'd0, 32'd0);
        sync();
        wen = 2'b00;
        push("dual_rd", M_R0 | M_R1 | M_N, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0011,
             32'd0, 32'h0000_0011);

        // Fill x1..x31
        for (int i = 1; i < 32; i++) begin
            sync();
            wen = 2'b01; waddr = {5'd0, 5'(i)}; wdata = {32'd0, 32'h0000_0100 + 32'(i)};
            raddr = {5'd0, 5'(i)};
            push($sformatf("fill%0d", i), M_R0, 1'b0, 1'b0, 32'h0000_0100 + 32'(i),
                 32'd0, 32'd0, 32'd0);
        end
        sync();
        wen = 2'b00; raddr = {5'd1, 5'd31}; dbg_addr = 5'd12;
        push("fill_rd", M_R0 | M_R1 | M_D, 1'b0, 1'b0, 32'h0000_011F, 32'h0000_0101,
             32'h0000_010C, 32'd0);

        // clr_req: same-cycle write commits, then gets cleared
        sync();
        clr_req = 1'b1; wen = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'd0, 32'h0000_00CC};
        raddr = {5'd31, 5'd12};
        push("clr_req", M_B | M_R0, 1'b0, 1'b0, 32'h0000_00CC, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k <= 32; k++) begin
            sync();
            clr_req = (k == 20);
            wen = (k < 32) ? 2'b01 : 2'b00;
            wdata = {32'd0, 32'h0000_00EE}; dbg_addr = 5'd31;
            push($sformatf("creq%0d", k), M_B | M_C | M_R0 | M_R1 | M_D, (k < 32), 1'b0,
                 32'd0, 32'd0, 32'd0, 32'd0);
        end
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sync();
            raddr = {5'(31 - i), 5'(i)}; dbg_addr = 5'(i);
            push($sformatf("sweep%0d", i), M_R0 | M_R1 | M_D | M_N, 1'b0, 1'b0,
                 32'd0, 32'd0, 32'd0, 32'd0);
        end

        // Reset in the middle of a clear restarts the full sequence
        sync();
        clr_req = 1'b1;
        push("mid_req", M_B, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k < 10; k++) begin
            sync();
            clr_req = 1'b0;
            push($sformatf("mid%0d", k), M_B, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        end
        sync();
        rst = 1'b1;
        push("mid_rst", M_B | M_R0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        sync();
        push("mid_rst2", M_B, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        sync();
        rst = 1'b0;
        push("rclr0", M_B, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            sync();
            push($sformatf("rclr%0d", k), M_B, (k < 32), 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        end

        // First write after the restarted clear
        sync();
        wen = 2'b10; waddr = {5'd4, 5'd0}; wdata = {32'h0000_0044, 32'd0};
        raddr = {5'd4, 5'd4}; dbg_addr = 5'd4;
        push("post_wr", M_ALL, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0044, 32'd0, 32'd0);
        sync();
        wen = 2'b00;
        push("post_rd", M_ALL, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0044, 32'h0000_0044,
             32'h0000_0044);

        sync();
        sync();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040000_mp_regfile.md
# ysyx_22040000_mp_regfile

Parametrised multi-ported integer register file for the NPC core; successor to the single-write/dual-read register file. Adds a configurable number of read and write ports, optional write-to-read bypass, an optional hard-wired zero register, and a hardware clear sequencer that zeroes the array after reset or on request. The block sits between decode (read ports) and writeback (write ports).

## Interface
- AWIDTH, 5: address width; depth = 2**AWIDTH.
- DWIDTH, 32: data width.
- NREAD, 2: read port count (≥1).
- NWRITE, 1: write port count (≥1).
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads.
- ZERO_REG, 1: 1 = address 0 reads 0, writes to it dropped.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  request full array clear.
- wen  in  NWRITE  per-port write enable.
- waddr  in  NWRITE*AWIDTH  write addresses, port i at [i*AWIDTH +: AWIDTH].
- wdata  in  NWRITE*DWIDTH  write data, port i at [i*DWIDTH +: DWIDTH].
- raddr  in  NREAD*AWIDTH  read addresses, packed as waddr.
- rdata  out  NREAD*DWIDTH  read data, packed as wdata.
- busy  out  1  clear sequence in progress.
- wr_conflict  out  1  two or more enabled write ports target the same effective address this cycle.
- dbg_addr  in  AWIDTH  debug read address.
- dbg_data  out  DWIDTH  debug read data (no bypass).

## Operation
- FSM states: CLEAR, READY. rst asserted → CLEAR, clear counter = 0, busy = 1.
- CLEAR: each cycle write 0 to entry[counter], counter +1; when counter = 2**AWIDTH−1 written, next state READY. All write ports ignored. rdata and dbg_data forced to 0. wr_conflict = 0. clr_req ignored (no restart).
- READY: busy = 0. clr_req = 1 at an edge → CLEAR with counter = 0; writes in that same cycle still commit (their effect is then overwritten by the clear).
- Write port i effective when wen[i] = 1, state READY, and not (ZERO_REG and waddr_i = 0).
- Multiple effective writes to the same address: highest port index wins; wr_conflict = 1 combinationally in that cycle.
- Read port j: combinational. If ZERO_REG and raddr_j = 0 → 0. Else if BYPASS and an effective write matches raddr_j → wdata of highest-index matching port. Else entry[raddr_j].
- dbg_data = entry[dbg_addr] (0 for address 0 when ZERO_REG), never bypassed.
- Counter width AWIDTH+1 or terminal compare at all-ones; no wrap into READY early.

## Timing
- Reset values: busy = 1, rdata = 0, dbg_data = 0, wr_conflict = 0, FSM = CLEAR, counter = 0.
- Clear latency: busy high for exactly 2**AWIDTH cycles after the first rising edge with rst low; first accepted write on edge 2**AWIDTH+1.
- Write latency: committed at the rising edge; visible on non-bypassed reads the following cycle, same cycle with BYPASS = 1.
- rst asserted mid-clear or mid-operation: immediate return to CLEAR, counter = 0, full clear restarted; array contents undefined until clear completes but never observable (reads forced 0).
- clr_req in READY: busy rises the next cycle, stays high 2**AWIDTH cycles.
- No simulation-only display/cycle-print logic in this block.

## Structure
- Shared package: state enum (CLEAR, READY), default AWIDTH/DWIDTH constants.
- One sub-module natural: ysyx_22040000_rf_wsel — combinational priority selector returning hit flag and winning wdata for one address across NWRITE ports; instantiated per read port for bypass and once per array entry or per write for commit.
- Packed flat port vectors; unpacking via generate loops.

## Test plan
- Reset then idle: release rst; busy = 1 for 32 cycles (AWIDTH = 5), 0 on cycle 33; all rdata = 0 throughout.
- Basic write/read: write 0xDEADBEEF to x5, next cycle raddr0 = 5 → 0xDEADBEEF; write to x0 then read x0 → 0.
- Bypass: BYPASS = 1, wen to x7 = 0x1234 with raddr1 = 7 same cycle → rdata1 = 0x1234; with BYPASS = 0 → old value 0.
- Write conflict: NWRITE = 2, both ports write x3 (0xA, 0xB) → wr_conflict = 1, x3 = 0xB afterwards.
- clr_req: fill x1..x31 with nonzero, pulse clr_req → busy 32 cycles, writes during clear dropped, then all reads = 0.
- Reset mid-clear: assert rst at clear cycle 10 → busy stays 1, counter restarts, busy falls exactly 32 cycles after rst release.
